// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SD CMD-line engine.
// Sends a 48-bit command frame with CRC7, then optionally receives a 48-bit
// or 136-bit response with timeout, CRC/framing checks, automatic retry and
// an enforced idle gap between transactions. The pad uses split in/out/oe.
// Optional build macro: SD_CMD_IDX_CHECK_EN (compare the response index field).
module sd_cmd_engine #(
    parameter int TIMEOUT     = 64,
    parameter int MAX_RETRIES = 3,
    parameter int NCC         = 8
) (
    input  logic         iclk,
    input  logic         irst_n,
    input  logic         istart,
    input  logic [5:0]   icmd_index,
    input  logic [31:0]  icmd_arg,
    input  logic [1:0]   iresp_type,
    input  logic         icmd_sd,
    output logic         ocmd_sd,
    output logic         ocmd_oe,
    output logic [119:0] oresp,
    output logic         obusy,
    output logic         odone,
    output logic         ocrc_err,
    output logic         otimeout,
    output logic [1:0]   oretries
);

    typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_RCV, ST_GAP} state_t;

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0] NCC_LAST = 16'(NCC - 1);
    localparam logic [1:0]  MAX_R    = 2'(MAX_RETRIES);

    // CRC7 (x^7+x^3+1, init 0), MSB first; leading zeros leave the CRC at 0,
    // so shorter fields are right-aligned in the 120-bit input.
    function automatic logic [6:0] crc7(input logic [119:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = 7'd0;
        for (int i = 119; i >= 0; i--) begin
            fb  = crc[6] ^ data[i];
            crc = {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
        end
        return crc;
    endfunction

    // Full 48-bit command frame: start, transmission, index, arg, crc, end.
    function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] body;
        body = {2'b01, idx, arg};
        return {body, crc7({80'd0, body}), 1'b1};
    endfunction

    state_t         state_r, state_next_s;
    logic [15:0]    cnt_r;
    logic [47:0]    tx_sr_r;
    logic           oe_r;
    logic [134:0]   rx_sr_r;
    logic [5:0]     idx_r;
    logic [31:0]    arg_r;
    logic [1:0]     type_r;
    logic           fail_r;
    logic [119:0]   resp_r;
    logic           busy_r, done_r, crc_err_r, timeout_r;
    logic [1:0]     retries_r;

    logic           accept_s, resend_s, finish_s, to_s, start_rx_s, rx_done_s;
    logic           last_rx_s;
    logic [119:0]   crc_in_s, resp_s;
    logic [6:0]     crc_rx_s;
    logic           rsp_fail_s;
    logic [47:0]    frame_s;

    assign ocmd_sd  = tx_sr_r[47];
    assign ocmd_oe  = oe_r;
    assign oresp    = resp_r;
    assign obusy    = busy_r;
    assign odone    = done_r;
    assign ocrc_err = crc_err_r;
    assign otimeout = timeout_r;
    assign oretries = retries_r;

    // Frame source: live inputs on a new command, latched fields on a resend.
    always_comb begin
        frame_s = build_frame(accept_s ? icmd_index : idx_r, accept_s ? icmd_arg : arg_r);
    end

    // Response evaluation at the end bit; rx_sr_r holds everything before it.
    always_comb begin
        last_rx_s  = (cnt_r == ((type_r == 2'b10) ? 16'd134 : 16'd46));
        crc_rx_s   = rx_sr_r[6:0];
        rsp_fail_s = 1'b0;
        if (type_r == 2'b10) begin
            crc_in_s   = rx_sr_r[126:7];
            resp_s     = rx_sr_r[126:7];
            rsp_fail_s = rx_sr_r[134] | rx_sr_r[133] | (crc7(crc_in_s) != crc_rx_s) | ~icmd_sd;
        end else begin
            crc_in_s   = {80'd0, rx_sr_r[46:7]};
            resp_s     = {82'd0, rx_sr_r[44:7]};
            rsp_fail_s = rx_sr_r[45] | ~icmd_sd;
            if (type_r != 2'b11) begin
                rsp_fail_s = rsp_fail_s | (crc7(crc_in_s) != crc_rx_s);
            end else begin
                rsp_fail_s = rsp_fail_s;
            end
`ifdef SD_CMD_IDX_CHECK_EN
            if (type_r == 2'b11) begin
                rsp_fail_s = rsp_fail_s | (rx_sr_r[44:39] != 6'b111111);
            end else begin
                rsp_fail_s = rsp_fail_s | (rx_sr_r[44:39] != idx_r);
            end
`endif
        end
    end

    // Next-state logic and single-cycle control strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        resend_s     = 1'b0;
        finish_s     = 1'b0;
        to_s         = 1'b0;
        start_rx_s   = 1'b0;
        rx_done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (istart) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (cnt_r == 16'd47) begin
                    state_next_s = (type_r == 2'b00) ? ST_GAP : ST_WAIT;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_WAIT: begin
                if (!icmd_sd) begin
                    start_rx_s   = 1'b1;
                    state_next_s = ST_RCV;
                end else if (cnt_r == TO_LAST) begin
                    to_s         = 1'b1;
                    state_next_s = ST_GAP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RCV: begin
                if (last_rx_s) begin
                    rx_done_s    = 1'b1;
                    state_next_s = ST_GAP;
                end else begin
                    state_next_s = ST_RCV;
                end
            end
            ST_GAP: begin
                if (cnt_r == NCC_LAST) begin
                    if (fail_r && (retries_r < MAX_R)) begin
                        resend_s     = 1'b1;
                        state_next_s = ST_SEND;
                    end else begin
                        finish_s     = 1'b1;
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) state_r <= ST_IDLE;
        else         state_r <= state_next_s;
    end

    // Datapath: counters, shift registers, latched command and result flags.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            cnt_r     <= 16'd0;
            tx_sr_r   <= {48{1'b1}};
            oe_r      <= 1'b0;
            rx_sr_r   <= 135'd0;
            idx_r     <= 6'd0;
            arg_r     <= 32'd0;
            type_r    <= 2'b00;
            fail_r    <= 1'b0;
            resp_r    <= 120'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            crc_err_r <= 1'b0;
            timeout_r <= 1'b0;
            retries_r <= 2'd0;
        end else begin
            done_r <= finish_s;
            cnt_r  <= ((state_next_s != state_r) || (state_r == ST_IDLE)) ? 16'd0 : cnt_r + 16'd1;
            if (accept_s || resend_s) begin
                tx_sr_r <= frame_s;
                oe_r    <= 1'b1;
            end else if (state_r == ST_SEND) begin
                tx_sr_r <= {tx_sr_r[46:0], 1'b1};
                oe_r    <= (cnt_r != 16'd47);
            end else begin
                tx_sr_r <= tx_sr_r;
                oe_r    <= 1'b0;
            end
            if (start_rx_s) rx_sr_r <= 135'd0;
            else if (state_r == ST_RCV) rx_sr_r <= {rx_sr_r[133:0], icmd_sd};
            else rx_sr_r <= rx_sr_r;
            if (accept_s) begin
                idx_r     <= icmd_index;
                arg_r     <= icmd_arg;
                type_r    <= iresp_type;
                fail_r    <= 1'b0;
                busy_r    <= 1'b1;
                crc_err_r <= 1'b0;
                timeout_r <= 1'b0;
                retries_r <= 2'd0;
            end else if (rx_done_s) begin
                resp_r <= resp_s;
                fail_r <= rsp_fail_s;
            end else if (to_s) begin
                timeout_r <= 1'b1;
            end else if (resend_s) begin
                retries_r <= retries_r + 2'd1;
                crc_err_r <= 1'b0;
                fail_r    <= 1'b0;
            end else if (finish_s) begin
                crc_err_r <= fail_r;
                busy_r    <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed testbench for sd_cmd_engine with a simple CMD-line device model.
module tb_sd_cmd_engine;

    logic         iclk = 1'b0;
    logic         irst_n, istart, icmd_sd;
    logic [5:0]   icmd_index;
    logic [31:0]  icmd_arg;
    logic [1:0]   iresp_type;
    logic         ocmd_sd, ocmd_oe, obusy, odone, ocrc_err, otimeout;
    logic [119:0] oresp;
    logic [1:0]   oretries;

    int n_cmp = 0;
    int n_err = 0;

    logic [47:0]  cap_frame;
    int           n_frames, done_t, oe_cycles;
    logic         busy0, busy_done;
    logic [127:0] cid_v;
    logic [135:0] rsp_v;

    always #5 iclk = ~iclk;

    sd_cmd_engine #(.TIMEOUT(64), .MAX_RETRIES(2), .NCC(8)) dut (
        .iclk(iclk), .irst_n(irst_n), .istart(istart), .icmd_index(icmd_index),
        .icmd_arg(icmd_arg), .iresp_type(iresp_type), .icmd_sd(icmd_sd),
        .ocmd_sd(ocmd_sd), .ocmd_oe(ocmd_oe), .oresp(oresp), .obusy(obusy),
        .odone(odone), .ocrc_err(ocrc_err), .otimeout(otimeout), .oretries(oretries)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference CRC7 over the low n bits of d, MSB first.
    function automatic logic [6:0] ref_crc7(input logic [119:0] d, input int n);
        logic [6:0] c;
        logic       msb;
        c = 7'd0;
        for (int i = n - 1; i >= 0; i--) begin
            msb = c[6];
            c   = c << 1;
            if (msb ^ d[i]) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // One transaction: issue the command, capture the first frame, answer
    // every frame with rsp (rlen bits) starting dly cycles after oe drops.
    task automatic do_xfer(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                           input logic [135:0] rsp, input int rlen, input int dly);
        int   t, bits_cap, bit_i, drive_t;
        logic prev_oe, done_seen;
        @(negedge iclk);
        icmd_index = idx; icmd_arg = arg; iresp_type = typ; istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
        t = 0; n_frames = 0; oe_cycles = 0; bits_cap = 0; cap_frame = 48'd0;
        prev_oe = 1'b0; bit_i = rlen; drive_t = 0; done_seen = 1'b0; busy0 = obusy;
        while (!done_seen && t < 3000) begin
            if (ocmd_oe) begin
                oe_cycles++;
                if (!prev_oe) n_frames++;
                if (n_frames == 1 && bits_cap < 48) begin
                    cap_frame = {cap_frame[46:0], ocmd_sd};
                    bits_cap++;
                end
            end else if (prev_oe && rlen > 0) begin
                bit_i = 0;
                drive_t = t + dly;
            end
            if (!ocmd_oe && bit_i < rlen && t >= drive_t) begin
                icmd_sd = rsp[rlen - 1 - bit_i];
                bit_i++;
            end else begin
                icmd_sd = 1'b1;
            end
            prev_oe = ocmd_oe;
            if (odone) begin
                done_seen = 1'b1;
                done_t    = t;
                busy_done = obusy;
            end else begin
                @(negedge iclk);
                t++;
            end
        end
        check_val("done_seen", 128'(done_seen), 128'd1);
        icmd_sd = 1'b1;
    endtask

    initial begin
        irst_n = 1'b0; istart = 1'b0; icmd_sd = 1'b1;
        icmd_index = 6'd0; icmd_arg = 32'd0; iresp_type = 2'b00;
        repeat (3) @(negedge iclk);
        check_val("rst_oe", 128'(ocmd_oe), 128'd0);
        check_val("rst_sd", 128'(ocmd_sd), 128'd1);
        check_val("rst_busy", 128'(obusy), 128'd0);
        check_val("rst_done", 128'(odone), 128'd0);
        check_val("rst_resp", 128'(oresp), 128'd0);
        check_val("rst_flags", 128'({ocrc_err, otimeout, oretries}), 128'd0);
        irst_n = 1'b1;
        repeat (2) @(negedge iclk);

        // CMD0, no response
        do_xfer(6'd0, 32'd0, 2'b00, 136'd0, 0, 0);
        check_val("cmd0_frame", 128'(cap_frame), 128'h400000000095);
        check_val("cmd0_done_t", 128'(done_t), 128'd56);
        check_val("cmd0_frames", 128'(n_frames), 128'd1);
        check_val("cmd0_oe_cyc", 128'(oe_cycles), 128'd48);
        check_val("cmd0_busy0", 128'(busy0), 128'd1);
        check_val("cmd0_busy_end", 128'(busy_done), 128'd0);
        check_val("cmd0_flags", 128'({ocrc_err, otimeout, oretries}), 128'd0);

        // CMD8 with valid R7 reply
        do_xfer(6'd8, 32'h000001AA, 2'b01, 136'h08000001AA13, 48, 5);
        check_val("cmd8_frame", 128'(cap_frame), 128'h48000001AA87);
        check_val("cmd8_resp", 128'(oresp), 128'h08000001AA);
        check_val("cmd8_crc", 128'(ocrc_err), 128'd0);
        check_val("cmd8_retries", 128'(oretries), 128'd0);
        check_val("cmd8_frames", 128'(n_frames), 128'd1);

        // CMD8 with bad reply CRC every time -> two resends
        do_xfer(6'd8, 32'h000001AA, 2'b01, 136'h08000001AA15, 48, 5);
        check_val("bad_frames", 128'(n_frames), 128'd3);
        check_val("bad_crc", 128'(ocrc_err), 128'd1);
        check_val("bad_retries", 128'(oretries), 128'd2);
        check_val("bad_resp", 128'(oresp), 128'h08000001AA);

        // No reply -> timeout, no resend
        do_xfer(6'd55, 32'h00000000, 2'b01, 136'd0, 0, 0);
        check_val("to_flag", 128'(otimeout), 128'd1);
        check_val("to_frames", 128'(n_frames), 128'd1);
        check_val("to_oe_cyc", 128'(oe_cycles), 128'd48);
        check_val("to_done_t", 128'(done_t), 128'd120);
        check_val("to_crc", 128'(ocrc_err), 128'd0);

        // CMD2 with 136-bit CID reply
        cid_v = 128'h035344534430308012345678012301FF;
        rsp_v = {2'b00, 6'b111111, cid_v[127:8], ref_crc7(cid_v[127:8], 120), 1'b1};
        do_xfer(6'd2, 32'd0, 2'b10, rsp_v, 136, 2);
        check_val("cid_resp", 128'(oresp), 128'(cid_v[127:8]));
        check_val("cid_crc", 128'(ocrc_err), 128'd0);
        check_val("cid_timeout", 128'(otimeout), 128'd0);

        // Reset in the middle of SEND
        @(negedge iclk);
        icmd_index = 6'd17; icmd_arg = 32'h12345678; iresp_type = 2'b01; istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
        repeat (20) @(negedge iclk);
        check_val("mid_oe_before", 128'(ocmd_oe), 128'd1);
        #1 irst_n = 1'b0;
        #1;
        check_val("mid_oe_drop", 128'(ocmd_oe), 128'd0);
        check_val("mid_sd_idle", 128'(ocmd_sd), 128'd1);
        @(negedge iclk);
        irst_n = 1'b1;
        @(negedge iclk);
        check_val("mid_busy", 128'(obusy), 128'd0);
        check_val("mid_oe_after", 128'(ocmd_oe), 128'd0);
        do_xfer(6'd0, 32'd0, 2'b00, 136'd0, 0, 0);
        check_val("post_rst_frame", 128'(cap_frame), 128'h400000000095);
        check_val("post_rst_done_t", 128'(done_t), 128'd56);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
